// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if: MEM/WB-to-writeback bus plus decode read ports and hazard/debug outputs
//   master: pipeline side (drives MEM/WB fields and decode read addresses, receives results)
//   slave : writeback/regfile side (consumes the fields, drives read data, result, strobes and count)
interface writeback_regfile_if #(
  parameter int width = 32,
  parameter int CNTW  = 32
);
  logic [width-1:0] ReadDataW;
  logic [width-1:0] ALUOutW;
  logic [4:0]       WriteRegW;
  logic             RegWriteW;
  logic             MemtoRegW;
  logic [4:0]       A1;
  logic [4:0]       A2;
  logic [width-1:0] RD1;
  logic [width-1:0] RD2;
  logic [width-1:0] ResultW;
  logic [4:0]       WriteRegOutW;
  logic             RegWriteOutW;
  logic [CNTW-1:0]  CommitCount;
  modport master (
    output ReadDataW, ALUOutW, WriteRegW, RegWriteW, MemtoRegW, A1, A2,
    input  RD1, RD2, ResultW, WriteRegOutW, RegWriteOutW, CommitCount
  );
  modport slave (
    input  ReadDataW, ALUOutW, WriteRegW, RegWriteW, MemtoRegW, A1, A2,
    output RD1, RD2, ResultW, WriteRegOutW, RegWriteOutW, CommitCount
  );
endinterface

// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback result select and 31-entry register file with same-cycle write bypass
//   clk   : pipeline clock, state updates on rising edge
//   rst_n : asynchronous active-low reset (clears registers and commit counter)
//   bus   : writeback_regfile_if.slave -- MEM/WB fields and A1/A2 in; RD1/RD2, ResultW,
//           WriteRegOutW, RegWriteOutW, CommitCount out
module writeback_regfile #(
  parameter int width = 32,
  parameter int CNTW  = 32
) (
  input logic               clk,
  input logic               rst_n,
  writeback_regfile_if.slave bus
);
  logic [width-1:0] regs [1:31];
  logic [CNTW-1:0]  cnt;
  logic             we;
  assign bus.ResultW = bus.MemtoRegW ? bus.ReadDataW : bus.ALUOutW;
  // Gating with rst_n suppresses the bypass and strobes while reset is held.
  assign we = rst_n && bus.RegWriteW && (bus.WriteRegW != 5'd0);
  assign bus.RegWriteOutW = we;
  assign bus.WriteRegOutW = we ? bus.WriteRegW : 5'd0;
  assign bus.CommitCount = cnt;
  always_comb begin
    bus.RD1 = (bus.A1 == 5'd0) ? '0 : (we && bus.A1 == bus.WriteRegW) ? bus.ResultW : regs[bus.A1];
    bus.RD2 = (bus.A2 == 5'd0) ? '0 : (we && bus.A2 == bus.WriteRegW) ? bus.ResultW : regs[bus.A2];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
      cnt <= '0;
    end else if (we) begin
      regs[bus.WriteRegW] <= bus.ResultW;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;
  localparam int W = 32;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  logic [W-1:0] mdl [32];
  int unsigned mcnt;
  writeback_regfile_if #(.width(W), .CNTW(C)) bus ();
  writeback_regfile #(.width(W), .CNTW(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mcnt = 0;
  endtask

  function automatic logic [W-1:0] m_res();
    return bus.MemtoRegW ? bus.ReadDataW : bus.ALUOutW;
  endfunction

  function automatic bit m_we();
    return rst_n === 1'b1 && bus.RegWriteW && bus.WriteRegW != 0;
  endfunction

  function automatic logic [W-1:0] m_rd(input logic [4:0] a);
    if (a == 0) return '0;
    if (m_we() && a == bus.WriteRegW) return m_res();
    return mdl[a];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":ResultW"}, bus.ResultW, m_res());
    chk({tag, ":RegWriteOutW"}, {31'b0, bus.RegWriteOutW}, {31'b0, m_we()});
    chk({tag, ":WriteRegOutW"}, {27'b0, bus.WriteRegOutW}, m_we() ? {27'b0, bus.WriteRegW} : '0);
    chk({tag, ":RD1"}, bus.RD1, m_rd(bus.A1));
    chk({tag, ":RD2"}, bus.RD2, m_rd(bus.A2));
    chk({tag, ":CommitCount"}, {28'b0, bus.CommitCount}, mcnt % 16);
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [4:0] wr,
                       input logic [W-1:0] alu, input logic [W-1:0] rdd,
                       input logic [4:0] a1, input logic [4:0] a2);
    bus.RegWriteW = rw;
    bus.MemtoRegW = m2r;
    bus.WriteRegW = wr;
    bus.ALUOutW = alu;
    bus.ReadDataW = rdd;
    bus.A1 = a1;
    bus.A2 = a2;
  endtask

  task automatic commit();
    logic [W-1:0] r;
    bit w;
    r = m_res();
    w = m_we();
    @(posedge clk);
    if (w && rst_n === 1'b1) begin
      mdl[bus.WriteRegW] = r;
      mcnt++;
    end
    #2;
  endtask

  task automatic step(input string tag, input logic rw, input logic m2r, input logic [4:0] wr,
                      input logic [W-1:0] alu, input logic [W-1:0] rdd,
                      input logic [4:0] a1, input logic [4:0] a2);
    drive(rw, m2r, wr, alu, rdd, a1, a2);
    #1;
    check_all(tag);
    commit();
  endtask

  initial begin
    rst_n = 1'b0;
    mdl_reset();
    drive(1'b1, 1'b0, 5'd5, 32'hCAFE_0001, 32'h0, 5'd5, 5'd5);
    #3;
    chk("rst_bypass_rd1", bus.RD1, 32'h0);
    chk("rst_we_strobe", {31'b0, bus.RegWriteOutW}, 32'h0);
    chk("rst_result_comb", bus.ResultW, 32'hCAFE_0001);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(a), 5'(31 - a));
      #1;
      chk("rst_sweep_rd1", bus.RD1, 32'h0);
      chk("rst_sweep_rd2", bus.RD2, 32'h0);
    end
    chk("rst_count", {28'b0, bus.CommitCount}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    step("w5", 1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'h0, 5'd5, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);
    #1;
    chk("r5_stored", bus.RD1, 32'h1234_5678);
    chk("count_one", {28'b0, bus.CommitCount}, 32'h1);
    commit();
    step("w0", 1'b1, 1'b1, 5'd0, 32'h0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    chk("w0_count", {28'b0, bus.CommitCount}, 32'h1);
    step("w7a", 1'b1, 1'b0, 5'd7, 32'hA, 32'h0, 5'd7, 5'd7);
    drive(1'b1, 1'b0, 5'd7, 32'hB, 32'h0, 5'd7, 5'd7);
    #1;
    chk("w7b_byp_rd1", bus.RD1, 32'hB);
    chk("w7b_byp_rd2", bus.RD2, 32'hB);
    commit();
    step("r7", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7);
    chk("r7_count", {28'b0, bus.CommitCount}, 32'h3);
    step("w3", 1'b1, 1'b0, 5'd3, 32'h55, 32'h0, 5'd3, 5'd3);
    drive(1'b1, 1'b0, 5'd3, 32'h77, 32'h0, 5'd3, 5'd5);
    rst_n = 1'b0;
    mdl_reset();
    #1;
    chk("pulse_r3", bus.RD1, 32'h0);
    chk("pulse_r5", bus.RD2, 32'h0);
    chk("pulse_count", {28'b0, bus.CommitCount}, 32'h0);
    chk("pulse_wrout", {27'b0, bus.WriteRegOutW}, 32'h0);
    rst_n = 1'b1;
    #1;
    commit();
    step("post_pulse", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd5);
    chk("post_pulse_r3", bus.RD1, 32'h77);
    drive(1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 5'd9, 5'd0);
    rst_n = 1'b0;
    mdl_reset();
    commit();
    rst_n = 1'b1;
    step("drop_r9", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd3);
    chk("drop_r9_val", bus.RD1, 32'h0);
    for (int i = 1; i <= 16; i++) step("wrap", 1'b1, 1'b0, 5'(i), 32'(i * 3), 32'h0, 5'(i), 5'(i - 1));
    #1;
    chk("wrap_zero", {28'b0, bus.CommitCount}, 32'h0);
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wr;
      wr = 5'($urandom_range(0, 31));
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), wr, $urandom, $urandom,
           ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)));
    end
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(a), 5'(a));
      #1;
      chk("final_rd1", bus.RD1, m_rd(5'(a)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
